regfile_mp_scoreboard: RTL and testbench

- Parametrised successor to the core's 32x32 two-read/one-write register file.
- Adds N read ports, two write ports (W0 = ALU writeback, W1 = long-latency/load return) and write-to-read bypass.
- Adds a per-register pending scoreboard so the issue stage can detect RAW hazards on outstanding loads.
- Sits between decode/issue and the writeback stages of the pipeline.

---
 rtl/regfile_mp_scoreboard.sv | 119 +++++++++++
 tb/tb_regfile_mp_scoreboard.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with write-to-read bypass and a per-register
// pending scoreboard for outstanding long-latency (load) results.
// W0 carries ALU writeback and W1 carries load returns. A W1 write clears the
// pending bit of its register. A reserve marks a register pending.
module regfile_mp_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  w0_en,
    input  logic [AW-1:0]         w0_addr,
    input  logic [XLEN-1:0]       w0_data,
    input  logic                  w1_en,
    input  logic [AW-1:0]         w1_addr,
    input  logic [XLEN-1:0]       w1_data,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    output logic                  rsv_err,
    output logic                  wr_conflict,
    output logic [AW:0]           pending_count
);

    localparam int CW = AW + 1;

    logic [XLEN-1:0]  regs_reg  [NREGS];
    logic [XLEN-1:0]  regs_next [NREGS];
    logic [NREGS-1:0] pending_reg;
    logic [NREGS-1:0] pending_next;
    logic [CW-1:0]    pending_count_next;
    logic             rsv_err_reg;
    logic             wr_conflict_reg;

    logic w0_eff;
    logic w1_eff;
    logic rsv_valid;

    // Writes and reserves aimed at a hardwired-zero register 0 are dropped here,
    // so nothing downstream needs to treat register 0 as a special case.
    assign w0_eff    = w0_en  && !((ZERO_REG != 0) && (w0_addr  == '0));
    assign w1_eff    = w1_en  && !((ZERO_REG != 0) && (w1_addr  == '0));
    assign rsv_valid = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Per-register next state: W1 beats W0 on data; reserve beats W1 on the pending bit.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            logic w0_hit;
            logic w1_hit;
            logic rsv_hit;
            assign w0_hit  = w0_eff    && (w0_addr  == AW'(gi));
            assign w1_hit  = w1_eff    && (w1_addr  == AW'(gi));
            assign rsv_hit = rsv_valid && (rsv_addr == AW'(gi));
            assign regs_next[gi]    = w1_hit ? w1_data : (w0_hit ? w0_data : regs_reg[gi]);
            assign pending_next[gi] = rsv_hit ? 1'b1 : (w1_hit ? 1'b0 : pending_reg[gi]);
        end
    endgenerate

    // Combinational read ports with bypass; a returning load stops reporting busy.
    generate
        for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] rd;
            assign ra = raddr[gi*AW +: AW];

            // Priority, lowest first, so later assignments win: array, W0, W1, zero.
            always_comb begin
                rd = regs_reg[ra];
                if ((BYPASS != 0) && w0_eff && (w0_addr == ra)) rd = w0_data;
                if ((BYPASS != 0) && w1_eff && (w1_addr == ra)) rd = w1_data;
                if ((ZERO_REG != 0) && (ra == '0))              rd = '0;
            end

            assign rdata[gi*XLEN +: XLEN] = rd;
            assign rbusy[gi] = pending_reg[ra] &
                               ~((BYPASS != 0) && w1_eff && (w1_addr == ra));
        end
    endgenerate

    // Popcount of the next-state pending vector so the count tracks the bits exactly.
    always_comb begin
        pending_count_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            pending_count_next = pending_count_next + CW'(pending_next[i]);
        end
    end

    // Register array update; reset clears every entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            regs_reg[i] <= rst ? regs_next[i] : '0;
        end
    end

    // Scoreboard state and the one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_reg     <= '0;
            pending_count   <= '0;
            rsv_err_reg     <= 1'b0;
            wr_conflict_reg <= 1'b0;
        end else begin
            pending_reg     <= pending_next;
            pending_count   <= pending_count_next;
            rsv_err_reg     <= rsv_valid && pending_reg[rsv_addr];
            wr_conflict_reg <= w0_eff && w1_eff && (w0_addr == w1_addr);
        end
    end

    assign rsv_err     = rsv_err_reg;
    assign wr_conflict = wr_conflict_reg;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Testbench for regfile_mp_scoreboard: directed scenarios plus randomized
// traffic checked against a behavioural model of registers and pending bits.
module tb_regfile_mp_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  clk;
    logic                  rst;
    logic [NREAD*AW-1:0]   raddr;
    logic [NREAD*XLEN-1:0] rdata;
    logic [NREAD-1:0]      rbusy;
    logic                  w0_en;
    logic [AW-1:0]         w0_addr;
    logic [XLEN-1:0]       w0_data;
    logic                  w1_en;
    logic [AW-1:0]         w1_addr;
    logic [XLEN-1:0]       w1_data;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_addr;
    logic                  rsv_err;
    logic                  wr_conflict;
    logic [AW:0]           pending_count;

    int tests_run;
    int tests_failed;

    // Reference model state
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_pend [NREGS];
    bit              m_err;
    bit              m_conf;
    int              m_cnt;

    regfile_mp_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_err(rsv_err),
        .wr_conflict(wr_conflict), .pending_count(pending_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: what a read port should return, given the model state and current inputs.
    function automatic logic [XLEN-1:0] exp_rdata(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (w1_en && w1_addr == a) return w1_data;
        if (w0_en && w0_addr == a) return w0_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_rbusy(input logic [AW-1:0] a);
        return m_pend[a] && !(w1_en && w1_addr == a && a != 0);
    endfunction

    // Advance one clock edge and apply the same edge to the model.
    task automatic cycle();
        bit e0, e1, rv;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
            m_err  = 1'b0;
            m_conf = 1'b0;
        end else begin
            e0 = w0_en && w0_addr != 0;
            e1 = w1_en && w1_addr != 0;
            rv = rsv_en && rsv_addr != 0;
            m_conf = e0 && e1 && (w0_addr == w1_addr);
            m_err  = rv && m_pend[rsv_addr];
            if (e0) m_regs[w0_addr] = w0_data;
            if (e1) m_regs[w1_addr] = w1_data;
            if (e1) m_pend[w1_addr] = 1'b0;
            if (rv) m_pend[rsv_addr] = 1'b1;
        end
        m_cnt = 0;
        for (int i = 0; i < NREGS; i++) m_cnt += int'(m_pend[i]);
        #1;
    endtask

    task automatic idle_inputs();
        w0_en = 0; w0_addr = 0; w0_data = 0;
        w1_en = 0; w1_addr = 0; w1_data = 0;
        rsv_en = 0; rsv_addr = 0;
    endtask

    task automatic test_reset();
        rst = 0; raddr = 0; idle_inputs();
        cycle(); cycle();
        rst = 1;
        #1;
        tests_run++;
        if (pending_count !== 0) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d want 0", pending_count);
        end
        for (int a = 0; a < NREGS; a++) begin
            raddr = {AW'(a), AW'(NREGS - 1 - a)};
            #1;
            tests_run++;
            if (rdata !== '0 || rbusy !== '0) begin
                tests_failed++;
                $display("FAIL reset_read a=%0d: rdata=%h rbusy=%b want 0/0", a, rdata, rbusy);
            end
        end
        $display("[TB] reset: all registers read 0");
    endtask

    task automatic test_bypass();
        w0_en = 1; w0_addr = 5; w0_data = 32'hDEADBEEF; raddr = {AW'(0), AW'(5)};
        #1;
        tests_run++;
        if (rdata[31:0] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL bypass_w0: got %h want deadbeef", rdata[31:0]);
        end
        cycle();
        w0_addr = 0; w0_data = 32'h1; raddr = {AW'(5), AW'(0)};
        #1;
        tests_run++;
        if (rdata[31:0] !== 0 || rdata[63:32] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL bypass_r0: got r0=%h r5=%h want 0/deadbeef", rdata[31:0], rdata[63:32]);
        end
        cycle();
        idle_inputs();
        #1;
        tests_run++;
        if (rdata[31:0] !== 0) begin
            tests_failed++;
            $display("FAIL r0_after_write: got %h want 0", rdata[31:0]);
        end
        $display("[TB] bypass: w0 r5=deadbeef, r0 stays 0");
    endtask

    task automatic test_reserve_release();
        rsv_en = 1; rsv_addr = 7; raddr = {AW'(7), AW'(0)};
        cycle();
        rsv_en = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (rbusy[1] !== 1'b1 || pending_count !== 1) begin
                tests_failed++;
                $display("FAIL rsv_wait%0d: rbusy1=%b count=%0d want 1/1", i, rbusy[1], pending_count);
            end
            cycle();
        end
        w1_en = 1; w1_addr = 7; w1_data = 32'h12345678;
        #1;
        tests_run++;
        if (rbusy[1] !== 1'b0 || rdata[63:32] !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL w1_release: rbusy1=%b rdata1=%h want 0/12345678", rbusy[1], rdata[63:32]);
        end
        cycle();
        w1_en = 0;
        #1;
        tests_run++;
        if (pending_count !== 0 || rbusy[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_count: count=%0d rbusy1=%b want 0/0", pending_count, rbusy[1]);
        end
        $display("[TB] reserve r7, w1 release");
    endtask

    task automatic test_conflict();
        w0_en = 1; w0_addr = 3; w0_data = 32'hAAAA;
        w1_en = 1; w1_addr = 3; w1_data = 32'hBBBB;
        cycle();
        idle_inputs(); raddr = {AW'(0), AW'(3)};
        #1;
        tests_run++;
        if (rdata[31:0] !== 32'hBBBB || wr_conflict !== 1'b1) begin
            tests_failed++;
            $display("FAIL conflict: r3=%h wr_conflict=%b want bbbb/1", rdata[31:0], wr_conflict);
        end
        cycle();
        tests_run++;
        if (wr_conflict !== 1'b0) begin
            tests_failed++;
            $display("FAIL conflict_pulse: wr_conflict=%b want 0", wr_conflict);
        end
        $display("[TB] write conflict on r3");
    endtask

    task automatic test_double_reserve();
        rsv_en = 1; rsv_addr = 9; raddr = {AW'(0), AW'(9)};
        cycle();
        tests_run++;
        if (rsv_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rsv_first: rsv_err=%b want 0", rsv_err);
        end
        cycle();
        tests_run++;
        if (rsv_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL rsv_second: rsv_err=%b want 1", rsv_err);
        end
        rsv_en = 0;
        cycle();
        tests_run++;
        if (rsv_err !== 1'b0 || pending_count !== 1) begin
            tests_failed++;
            $display("FAIL rsv_pulse: rsv_err=%b count=%0d want 0/1", rsv_err, pending_count);
        end
        rsv_en = 1; w1_en = 1; w1_addr = 9; w1_data = 32'h55;
        cycle();
        rsv_en = 0; w1_en = 0;
        #1;
        tests_run++;
        if (rbusy[0] !== 1'b1 || pending_count !== 1 || rdata[31:0] !== 32'h55) begin
            tests_failed++;
            $display("FAIL rsv_beats_clear: rbusy0=%b count=%0d r9=%h want 1/1/55",
                     rbusy[0], pending_count, rdata[31:0]);
        end
        rsv_en = 1; rsv_addr = 0;
        cycle(); cycle();
        rsv_en = 0;
        tests_run++;
        if (rsv_err !== 1'b0 || pending_count !== 1) begin
            tests_failed++;
            $display("FAIL rsv_r0: rsv_err=%b count=%0d want 0/1", rsv_err, pending_count);
        end
        w1_en = 1; w1_addr = 9; w1_data = 32'h66;
        cycle();
        w1_en = 0;
        $display("[TB] double reserve r9");
    endtask

    task automatic test_reset_midop();
        rsv_en = 1;
        rsv_addr = 2; cycle();
        rsv_addr = 4; cycle();
        rsv_addr = 6; cycle();
        rsv_en = 0;
        tests_run++;
        if (pending_count !== 3) begin
            tests_failed++;
            $display("FAIL three_pending: count=%0d want 3", pending_count);
        end
        rst = 0; w0_en = 1; w0_addr = 8; w0_data = 32'h77; rsv_en = 1; rsv_addr = 10;
        cycle();
        rst = 1; idle_inputs();
        #1;
        tests_run++;
        if (pending_count !== 0) begin
            tests_failed++;
            $display("FAIL midop_count: count=%0d want 0", pending_count);
        end
        for (int a = 0; a < NREGS; a++) begin
            raddr = {AW'(a), AW'(a)};
            #1;
            tests_run++;
            if (rdata !== '0 || rbusy !== '0) begin
                tests_failed++;
                $display("FAIL midop_read a=%0d: rdata=%h rbusy=%b want 0/0", a, rdata, rbusy);
            end
        end
        $display("[TB] reset mid-operation clears reservations");
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int t = 0; t < 400; t++) begin
            rst      = ($urandom_range(0, 60) != 0);
            w0_en    = $urandom_range(0, 1);
            w0_addr  = AW'($urandom_range(0, 7));
            w0_data  = $urandom;
            w1_en    = $urandom_range(0, 2) == 0;
            w1_addr  = AW'($urandom_range(0, 7));
            w1_data  = $urandom;
            rsv_en   = $urandom_range(0, 2) == 0;
            rsv_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            raddr    = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            #1;
            for (int k = 0; k < NREAD; k++) begin
                a = raddr[k*AW +: AW];
                tests_run++;
                if (rdata[k*XLEN +: XLEN] !== exp_rdata(a) || rbusy[k] !== exp_rbusy(a)) begin
                    tests_failed++;
                    $display("FAIL rand_read t=%0d port%0d a=%0d: rdata=%h rbusy=%b want %h/%b",
                             t, k, a, rdata[k*XLEN +: XLEN], rbusy[k], exp_rdata(a), exp_rbusy(a));
                end
            end
            cycle();
            tests_run++;
            if (rsv_err !== m_err || wr_conflict !== m_conf || pending_count !== (AW+1)'(m_cnt)) begin
                tests_failed++;
                $display("FAIL rand_state t=%0d: err=%b conf=%b count=%0d want %b/%b/%0d",
                         t, rsv_err, wr_conflict, pending_count, m_err, m_conf, m_cnt);
            end
            $display("[TB] txn %0d rst=%b w0=%b@%0d w1=%b@%0d rsv=%b@%0d count=%0d",
                     t, rst, w0_en, w0_addr, w1_en, w1_addr, rsv_en, rsv_addr, pending_count);
        end
        rst = 1; idle_inputs();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_bypass();
        test_reserve_release();
        test_conflict();
        test_double_reserve();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
